// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game controller.
//   - state_t      : controller FSM states
//   - DIR_*        : one-hot move directions, bit order {right,down,left,up}
//   - reverse_dir  : 180-degree opposite of a one-hot direction
//   - is_one_hot   : true when exactly one bit of a direction request is set
//   - *_DEF        : default values for the controller parameters
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam int TICK_BASE_DEF        = 1777778;
    localparam int TICK_STEP_DEF        = 160000;
    localparam int MAX_LEVEL_DEF        = 7;
    localparam int APPLES_PER_LEVEL_DEF = 8;

    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        logic [3:0] r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: loadable down-counter producing the periodic move pulse.
//   VGA_clk  in  : clock
//   rst      in  : synchronous active-high reset (counter and tick cleared)
//   load     in  : reload the counter with period-1 (highest priority)
//   en       in  : count enable; when low the counter holds its value
//   period   in  : tick period in clock cycles, sampled at each reload
//   tick     out : one-cycle registered pulse, once per period while enabled
//   tick_due out: combinational "tick is registered on this edge"; lets the
//                 parent update state that must change in the tick cycle
module snake_tick_gen #(
    parameter int W = 21
) (
    input  logic         VGA_clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick,
    output logic         tick_due
);

    logic [W-1:0] cnt;

    assign tick_due = en && !load && (cnt == '0);

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tick_due;
            if (load) begin
                cnt <= period - W'(1);
            end else if (en) begin
                // The period is re-read only here, so a level change
                // takes effect at the next reload.
                if (cnt == '0) cnt <= period - W'(1);
                else           cnt <= cnt - W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-flow controller for the VGA snake game.
//   VGA_clk    in  : 25 MHz pixel clock, sole clock
//   rst        in  : synchronous active-high reset
//   start_btn  in  : start/restart request level (rising edge acts)
//   pause_btn  in  : pause toggle request level (rising edge acts)
//   dir_req    in  : one-hot direction request {right,down,left,up}
//   apple_hit, wall_hit, self_hit in : head collision flags from datapath
//   init       out : one-cycle pulse resetting snake and apple
//   update     out : one-cycle move pulse
//   direction  out : committed one-hot move direction
//   grow       out : one-cycle grow/relocate-apple pulse
//   playing, paused, game_over out : state flags
//   score      out : apples eaten (saturating at 255)
//   level      out : speed level (saturating at MAX_LEVEL)
//   state_dbg  out : current FSM state encoding (state_t)
// Handshake: there is no valid/ready traffic here; every output pulse is a
// single-cycle strobe that the datapath consumes unconditionally.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_BASE        = TICK_BASE_DEF,
    parameter int TICK_STEP        = TICK_STEP_DEF,
    parameter int MAX_LEVEL        = MAX_LEVEL_DEF,
    parameter int APPLES_PER_LEVEL = APPLES_PER_LEVEL_DEF
) (
    input  logic       VGA_clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [3:0] dir_req,
    input  logic       apple_hit,
    input  logic       wall_hit,
    input  logic       self_hit,
    output logic       init,
    output logic       update,
    output logic [3:0] direction,
    output logic       grow,
    output logic       playing,
    output logic       paused,
    output logic       game_over,
    output logic [7:0] score,
    output logic [2:0] level,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = $clog2(TICK_BASE + 1);
    localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(TICK_BASE);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(TICK_STEP);
    localparam logic [2:0]       MAX_LVL_C = 3'(MAX_LEVEL);
    localparam logic [7:0]       APL_LAST  = 8'(APPLES_PER_LEVEL - 1);

    state_t     state, next_state;
    logic       start_q, pause_q;
    logic       start_edge, pause_edge;
    logic       update_q;
    logic [3:0] pending;
    logic [7:0] apple_cnt;
    logic       apple_taken;
    logic       sample_ok, collide, grow_set, init_set;
    logic       tick_en, tick_due;
    logic [CNT_W-1:0] period;

    assign start_edge = start_btn && !start_q;
    assign pause_edge = pause_btn && !pause_q;

    // Hits are only trusted one full cycle after a move has settled.
    assign sample_ok = (state == ST_PLAY) && !update && !update_q;
    assign collide   = wall_hit || self_hit;
    assign grow_set  = sample_ok && apple_hit && !collide && !apple_taken;

    assign period  = BASE_C - CNT_W'(level) * STEP_C;
    // Count only while staying in PLAY, so a leaving edge neither ticks
    // nor consumes a count.
    assign tick_en = (state == ST_PLAY) && (next_state == ST_PLAY);

    snake_tick_gen #(.W(CNT_W)) u_tick (
        .VGA_clk  (VGA_clk),
        .rst      (rst),
        .load     (init),
        .en       (tick_en),
        .period   (period),
        .tick     (update),
        .tick_due (tick_due)
    );

    always_ff @(posedge VGA_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        init_set   = 1'b0;
        playing    = (state == ST_PLAY);
        paused     = (state == ST_PAUSE);
        game_over  = (state == ST_OVER);
        state_dbg  = state;
        case (state)
            ST_IDLE, ST_OVER: begin
                // init is high for the cycle before PLAY; it doubles as
                // the launch marker so no extra state is needed.
                if (init)            next_state = ST_PLAY;
                else if (start_edge) init_set   = 1'b1;
            end
            ST_PLAY: begin
                if (sample_ok && collide) next_state = ST_OVER;
                else if (pause_edge)      next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_edge) next_state = ST_PLAY;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            update_q    <= 1'b0;
            init        <= 1'b0;
            grow        <= 1'b0;
            direction   <= DIR_NONE;
            pending     <= DIR_NONE;
            score       <= 8'd0;
            level       <= 3'd0;
            apple_cnt   <= 8'd0;
            apple_taken <= 1'b0;
        end else begin
            start_q  <= start_btn;
            pause_q  <= pause_btn;
            update_q <= update;
            init     <= init_set;
            grow     <= 1'b0;
            if (init_set) begin
                score       <= 8'd0;
                level       <= 3'd0;
                direction   <= DIR_NONE;
                pending     <= DIR_NONE;
                apple_cnt   <= 8'd0;
                apple_taken <= 1'b0;
            end else begin
                if (is_one_hot(dir_req)) pending <= dir_req;
                // Commit on the tick edge so direction changes in the
                // same cycle update is seen; reversals are refused.
                if (tick_due && (pending != DIR_NONE) &&
                    (pending != reverse_dir(direction)))
                    direction <= pending;
                if (update) begin
                    apple_taken <= 1'b0;
                end else if (grow_set) begin
                    grow        <= 1'b1;
                    apple_taken <= 1'b1;
                    if (score != 8'hFF) score <= score + 8'd1;
                    if (apple_cnt == APL_LAST) begin
                        apple_cnt <= 8'd0;
                        if (level != MAX_LVL_C) level <= level + 3'd1;
                    end else begin
                        apple_cnt <= apple_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed bench for snake_game_ctrl with short tick
// periods (base 20, step 2, two apples per level).
module tb_snake_game_ctrl;

    logic       VGA_clk = 1'b0;
    logic       rst, start_btn, pause_btn;
    logic [3:0] dir_req;
    logic       apple_hit, wall_hit, self_hit;
    logic       init, update, grow, playing, paused, game_over;
    logic [3:0] direction;
    logic [7:0] score;
    logic [2:0] level;
    logic [1:0] state_dbg;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_cyc, n_grow;
    logic       found;
    logic [7:0] exp_q[$];

    // clock / reset block
    always #5 VGA_clk = ~VGA_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    snake_game_ctrl #(
        .TICK_BASE(20), .TICK_STEP(2), .MAX_LEVEL(7), .APPLES_PER_LEVEL(2)
    ) dut (
        .VGA_clk(VGA_clk), .rst(rst), .start_btn(start_btn),
        .pause_btn(pause_btn), .dir_req(dir_req), .apple_hit(apple_hit),
        .wall_hit(wall_hit), .self_hit(self_hit), .init(init),
        .update(update), .direction(direction), .grow(grow),
        .playing(playing), .paused(paused), .game_over(game_over),
        .score(score), .level(level), .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard: expected update spacings are queued before each wait
    task automatic sb_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got %0d with no expected value queued", tag, got);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge VGA_clk);
    endtask

    task automatic wait_update(input int budget, output int n, output int g, output logic f);
        n = 0;
        g = 0;
        f = 1'b0;
        while (!f && n < budget) begin
            @(negedge VGA_clk);
            n++;
            if (grow)   g++;
            if (update) f = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; dir_req = 4'd0;
        apple_hit = 1'b0; wall_hit = 1'b0; self_hit = 1'b0;
        cyc(3);
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_init", 32'(init), 0);
        chk("rst_update", 32'(update), 0);
        chk("rst_direction", 32'(direction), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_flags", {29'd0, playing, paused, game_over}, 0);
        rst = 1'b0;
        cyc(2);
        chk("idle_hold", 32'(state_dbg), 0);

        // start: init on cycle 1, PLAY on cycle 2, then 20-cycle ticks
        start_btn = 1'b1;
        cyc(1);
        chk("start_init", 32'(init), 1);
        chk("start_not_playing", 32'(playing), 0);
        cyc(1);
        chk("init_one_cycle", 32'(init), 0);
        chk("start_playing", 32'(playing), 1);
        start_btn = 1'b0;
        exp_q.push_back(8'd20);
        wait_update(100, n_cyc, n_grow, found);
        chk("upd1_found", 32'(found), 1);
        sb_check("upd1_spacing", 8'(n_cyc));
        exp_q.push_back(8'd20);
        wait_update(100, n_cyc, n_grow, found);
        sb_check("upd2_spacing", 8'(n_cyc));

        // direction: up accepted from none, down refused, right accepted
        dir_req = 4'b0001; cyc(1); dir_req = 4'd0;
        wait_update(100, n_cyc, n_grow, found);
        chk("dir_up", 32'(direction), 4'b0001);
        dir_req = 4'b0100; cyc(1); dir_req = 4'd0;
        wait_update(100, n_cyc, n_grow, found);
        chk("dir_reverse_refused", 32'(direction), 4'b0001);
        dir_req = 4'b1000; cyc(1); dir_req = 4'd0;
        wait_update(100, n_cyc, n_grow, found);
        chk("dir_right", 32'(direction), 4'b1000);

        // apples: one grow per period, level 1 after two, then period 18
        apple_hit = 1'b1;
        wait_update(100, n_cyc, n_grow, found);
        chk("apple1_grows", 32'(n_grow), 1);
        chk("apple1_score", 32'(score), 1);
        chk("apple1_level", 32'(level), 0);
        wait_update(100, n_cyc, n_grow, found);
        chk("apple2_grows", 32'(n_grow), 1);
        chk("apple2_score", 32'(score), 2);
        chk("apple2_level", 32'(level), 1);
        apple_hit = 1'b0;
        exp_q.push_back(8'd18);
        wait_update(100, n_cyc, n_grow, found);
        sb_check("lvl1_spacing", 8'(n_cyc));
        chk("lvl1_no_grow", 32'(n_grow), 0);

        // collision with simultaneous apple, sampled after the settle cycle
        apple_hit = 1'b1; wall_hit = 1'b1;
        cyc(2);
        chk("settle_still_playing", 32'(playing), 1);
        cyc(1);
        chk("wall_game_over", 32'(game_over), 1);
        chk("wall_no_grow", 32'(grow), 0);
        chk("wall_score_hold", 32'(score), 2);
        apple_hit = 1'b0; wall_hit = 1'b0;
        wait_update(40, n_cyc, n_grow, found);
        chk("over_no_update", 32'(found), 0);
        chk("over_no_grow", 32'(n_grow), 0);
        chk("over_level_hold", 32'(level), 1);

        // restart from OVER
        start_btn = 1'b1;
        cyc(1);
        chk("restart_init", 32'(init), 1);
        chk("restart_score", 32'(score), 0);
        chk("restart_level", 32'(level), 0);
        chk("restart_dir", 32'(direction), 0);
        start_btn = 1'b0;
        cyc(1);
        chk("restart_playing", 32'(playing), 1);
        exp_q.push_back(8'd20);
        wait_update(100, n_cyc, n_grow, found);
        sb_check("restart_spacing", 8'(n_cyc));

        // pause 7 cycles into a period, hold ~50 cycles, resume
        cyc(7);
        pause_btn = 1'b1;
        cyc(1);
        chk("pause_entered", 32'(paused), 1);
        wait_update(20, n_cyc, n_grow, found);
        chk("pause_held_level", 32'(paused), 1);
        chk("pause_no_update_a", 32'(found), 0);
        start_btn = 1'b1;
        cyc(1);
        chk("pause_start_ignored", 32'(init), 0);
        start_btn = 1'b0; pause_btn = 1'b0;
        wait_update(29, n_cyc, n_grow, found);
        chk("pause_no_update_b", 32'(found), 0);
        chk("pause_still", 32'(paused), 1);
        pause_btn = 1'b1;
        cyc(1);
        chk("unpause_playing", 32'(playing), 1);
        pause_btn = 1'b0;
        exp_q.push_back(8'd13);
        wait_update(100, n_cyc, n_grow, found);
        sb_check("resume_spacing", 8'(n_cyc));

        // build score 5, then reset where a grow would have landed
        dir_req = 4'b0010; apple_hit = 1'b1;
        repeat (5) wait_update(100, n_cyc, n_grow, found);
        chk("pre_rst_score", 32'(score), 5);
        chk("pre_rst_level", 32'(level), 2);
        chk("pre_rst_dir", 32'(direction), 4'b0010);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_state", 32'(state_dbg), 0);
        chk("rst_mid_score", 32'(score), 0);
        chk("rst_mid_dir", 32'(direction), 0);
        chk("rst_mid_grow", 32'(grow), 0);
        chk("rst_mid_update", 32'(update), 0);
        chk("rst_mid_level", 32'(level), 0);
        rst = 1'b0; apple_hit = 1'b0; dir_req = 4'd0;
        cyc(2);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_BASE, default 1777778, update period in VGA_clk cycles at level 0.
REQ-002 SHALL have parameter TICK_STEP, default 160000, period reduction in cycles per level.
REQ-003 SHALL have parameter MAX_LEVEL, default 7, highest speed level.
REQ-004 SHALL have parameter APPLES_PER_LEVEL, default 8, apples eaten per level increment.
REQ-005 SHALL have port VGA_clk, input, 1, sole clock (25 MHz pixel clock).
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port start_btn, input, 1, start/restart request (level, already synchronised).
REQ-008 SHALL have port pause_btn, input, 1, pause toggle request (level, already synchronised).
REQ-009 SHALL have port dir_req, input, 4, keyboard direction {right,down,left,up} one-hot; 0000 means no request.
REQ-010 SHALL have port apple_hit, input, 1, head-on-apple flag from the datapath.
REQ-011 SHALL have port wall_hit, input, 1, head-on-border flag from the datapath.
REQ-012 SHALL have port self_hit, input, 1, head-on-body flag from the datapath.
REQ-013 SHALL have port init, output, 1, one-cycle pulse commanding the datapath to reset snake and apple.
REQ-014 SHALL have port update, output, 1, one-cycle move pulse.
REQ-015 SHALL have port direction, output, 4, committed one-hot move direction.
REQ-016 SHALL have port grow, output, 1, one-cycle pulse commanding a size increase and an apple relocation.
REQ-017 SHALL have ports playing, paused and game_over, outputs, 1 each, state flags.
REQ-018 SHALL have ports score (8 bits, apples eaten) and level (3 bits, current speed level), both outputs.

Function
REQ-019 SHALL implement FSM states IDLE, PLAY, PAUSE and OVER; the start state is IDLE.
REQ-020 SHALL act on rising edges of start_btn and pause_btn only; a held level SHALL have no further effect.
REQ-021 On a start edge in IDLE or OVER, SHALL pulse init for 1 cycle, clear score, level and direction, and enter PLAY on the next cycle.
REQ-022 A start edge in PLAY or PAUSE SHALL be ignored.
REQ-023 A pause edge SHALL toggle PLAY<->PAUSE and SHALL be ignored in IDLE and OVER.
REQ-024 In PAUSE, the tick counter SHALL freeze and resume from its held value on return to PLAY.
REQ-025 In PLAY, SHALL assert update for 1 cycle every TICK_BASE - level*TICK_STEP cycles; the first update SHALL occur exactly that many cycles after entering PLAY.
REQ-026 A dir_req value that is one-hot SHALL be stored as pending, with the newest request winning; any other value SHALL be ignored.
REQ-027 SHALL copy pending to direction on the same cycle update is asserted, unless pending is the 180-degree reverse of the current direction, in which case direction SHALL be unchanged.
REQ-028 When direction is 0000, any one-hot pending value SHALL be accepted.
REQ-029 Hit inputs SHALL be sampled only in PLAY, on cycles where update is low and the update pulse of the previous cycle is also low (one-cycle settle after each move).
REQ-030 When wall_hit or self_hit is sampled, the FSM SHALL enter OVER; collision SHALL take priority over a simultaneous apple_hit, which then produces no grow and no score change.
REQ-031 A sampled apple_hit SHALL produce exactly one grow pulse per update period, with further apple_hit cycles in that period ignored.
REQ-032 Each grow SHALL increment score, saturating at 255.
REQ-033 Each APPLES_PER_LEVEL grows SHALL increment level, saturating at MAX_LEVEL.
REQ-034 A new period SHALL take effect from the next tick reload.
REQ-035 In OVER, update and grow SHALL stay low, and score and level SHALL hold.

Reset
REQ-036 rst SHALL force: state IDLE; init, update and grow = 0; direction = 0000; pending = 0000; score = 0; level = 0; playing, paused and game_over = 0; tick counter = 0; button edge registers = 0.
REQ-037 rst asserted mid-PLAY SHALL abort within the same cycle, with no update or grow pulse on that edge.

Structure
REQ-038 Package snake_pkg SHALL hold the state enum, direction one-hot constants, a reverse-direction function, and parameter defaults.
REQ-039 The sub-module snake_tick_gen (loadable down-counter with enable and period input) SHALL generate update.

Verification
REQ-040 Sim params TICK_BASE=20, TICK_STEP=2, APPLES_PER_LEVEL=2: start edge -> init on cycle 1, playing on cycle 2, update pulses 20 cycles apart.
REQ-041 direction=0001 (up), dir_req=0100 then next update -> direction remains 0001; dir_req=1000 -> direction=1000 at the next update.
REQ-042 apple_hit held for a full period -> exactly one grow and score +1; after 2 apples -> level=1 and update spacing 18.
REQ-043 apple_hit and wall_hit asserted in the same sampling cycle -> game_over=1, no grow, score unchanged.
REQ-044 Pause edge at 7 cycles into a period, hold for 50 cycles, then unpause -> next update 13 cycles later; a start edge during PAUSE is ignored.
REQ-045 rst pulsed mid-PLAY with score=5 -> next cycle IDLE, score=0, direction=0000, no update or grow pulse.
